// File: rtl/demux4_buf_if.sv
// Handshake and data bundle for demux4_buf: one producer port, four buffered consumer ports.
// master = producer/consumer side driving d, s, in_valid, out_ready; slave = the demux itself.
interface demux4_buf_if #(
  parameter int N = 64
);
  logic [N-1:0] d;
  logic [1:0]   s;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] y0;
  logic [N-1:0] y1;
  logic [N-1:0] y2;
  logic [N-1:0] y3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [31:0]  xfer_count;

  modport master (
    output d, s, in_valid, out_ready,
    input  in_ready, y0, y1, y2, y3, out_valid, xfer_count
  );

  modport slave (
    input  d, s, in_valid, out_ready,
    output in_ready, y0, y1, y2, y3, out_valid, xfer_count
  );
endinterface

// File: rtl/demux4_buf.sv
// 1-to-4 demux with a one-word hold register per channel; 1-cycle latency, in_ready follows only the target channel.
// Define DEMUX4_ROUND_ROBIN_EN to ignore s and steer words round-robin (ch0..ch3) on each accept.
module demux4_buf #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  demux4_buf_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t    st  [4];
  logic [N-1:0] y_q [4];
  logic [31:0]  cnt;
  logic [1:0]   t;
  logic         acc;

`ifdef DEMUX4_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 2'd0;
    end else if (acc) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign t = rr_ptr;
`else
  assign t = bus.s;
`endif

  // A full target may still accept when it drains in the same cycle.
  assign bus.in_ready = (st[t] == EMPTY) | bus.out_ready[t];
  assign acc          = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= EMPTY;
        y_q[i] <= '0;
      end
      cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && (t == 2'(i))) begin
          st[i]  <= FULL;
          y_q[i] <= bus.d;
        end else if (bus.out_ready[i]) begin
          st[i]  <= EMPTY;
        end
      end
      if (acc) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  assign bus.out_valid  = {st[3] == FULL, st[2] == FULL, st[1] == FULL, st[0] == FULL};
  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.xfer_count = cnt;

endmodule
